// File: rtl/adc_ram_to_fft_reader.sv
// Reads a captured ADC frame from sample RAM in address order and streams it to the FFT core.
// A credit-limited FIFO absorbs the RAM read latency so FFT backpressure never drops or repeats a sample.
module adc_ram_to_fft_reader #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_SAMPLES = 16384,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = RAM_LATENCY + 2,
    parameter int TWOS_COMP   = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  capture_done,
    input  logic                  fft_finished,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] fft_data,
    output logic                  fft_valid,
    input  logic                  fft_ready,
    output logic                  fft_sop,
    output logic                  fft_eop,
    output logic                  capture_release,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | RAM owned by the capture writer, waiting for capture_done
    // READ     | issuing one read per cycle while FIFO credit remains
    // DRAIN    | every read issued, emptying the FIFO into the FFT
    // WAIT_FFT | frame delivered, waiting for the FFT to report completion
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DRAIN    = 2'd2,
        WAIT_FFT = 2'd3
    } state_t;

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(RAM_LATENCY + 1);
    localparam int SUM_W = ((FC_W > IF_W) ? FC_W : IF_W) + 1;

    localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [FC_W-1:0]  FC_FULL    = FC_W'(FIFO_DEPTH);
    localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(FIFO_DEPTH);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       sent_cnt;
    logic [RAM_LATENCY-1:0] inflight;
    logic [IF_W-1:0]        inflight_count;
    logic [FC_W-1:0]        fifo_count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  sample_conv;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   credit_ok;
    logic                   frame_start;
    logic                   release_next;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight_count = inflight_count + IF_W'(inflight[i]);
        end
    end

    // Every issued read owns a FIFO slot from issue until it is popped.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_count)) < CREDIT_MAX;

    assign push      = inflight[RAM_LATENCY-1];
    assign fft_valid = (fifo_count != '0);
    assign pop       = fft_valid && fft_ready;

    always_comb begin
        sample_conv = ram_q;
        if (TWOS_COMP != 0) begin
            sample_conv = {~ram_q[DATA_WIDTH-1], ram_q[DATA_WIDTH-2:0]};
        end
    end

    always_comb begin
        state_next   = state;
        issue        = 1'b0;
        frame_start  = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (capture_done) begin
                    state_next  = READ;
                    frame_start = 1'b1;
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_cnt == FRAME_LAST) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sent_cnt == FRAME_LEN) begin
                    state_next = WAIT_FFT;
                end
            end
            WAIT_FFT: begin
                if (fft_finished) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_rden    = issue;
    assign ram_address = issue_cnt[ADDR_WIDTH-1:0];
    assign busy        = (state != IDLE);

    assign fft_data = fft_valid ? fifo_mem[rd_ptr] : '0;
    assign fft_sop  = fft_valid && (sent_cnt == '0);
    assign fft_eop  = fft_valid && (sent_cnt == FRAME_LAST);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state           <= IDLE;
            issue_cnt       <= '0;
            sent_cnt        <= '0;
            inflight        <= '0;
            fifo_count      <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            capture_release <= 1'b0;
        end else begin
            state           <= state_next;
            capture_release <= release_next;
            inflight        <= (inflight << 1) | RAM_LATENCY'(issue);

            if (frame_start) begin
                issue_cnt <= '0;
                sent_cnt  <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (pop) begin
                    sent_cnt <= sent_cnt + CNT_ONE;
                end
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FC_ONE;
                2'b01:   fifo_count <= fifo_count - FC_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push && !RESET) begin
            fifo_mem[wr_ptr] <= sample_conv;
        end
    end

    // The credit check makes this unreachable; a hit means the credit accounting broke.
    fifo_no_overflow: assert property (@(posedge CLOCK) disable iff (RESET)
        !(push && (fifo_count == FC_FULL)));

endmodule

// File: tb/tb_adc_ram_to_fft_reader.sv
// Directed bench for adc_ram_to_fft_reader: 16-sample frames from a 2-cycle-latency RAM model,
// with a second instance configured for offset-binary to two's-complement conversion.
module tb_adc_ram_to_fft_reader;
    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int NS    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          capture_done = 1'b0, fft_finished = 1'b0, fft_ready = 1'b1;
    logic [AW-1:0] ram_address;
    logic          ram_rden, fft_valid, fft_sop, fft_eop, capture_release, busy;
    logic [DW-1:0] ram_q, q_p1, fft_data;

    logic          cd_tc = 1'b0, ff_tc = 1'b0, fr_tc = 1'b1;
    logic [AW-1:0] addr_tc;
    logic          rden_tc, fv_tc, sop_tc, eop_tc, rel_tc, busy_tc;
    logic [DW-1:0] q_tc, q_p1_tc, fd_tc;

    logic [DW-1:0] ram_mem [NS];
    logic [DW-1:0] ram_tc  [NS];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] beat_data [NS];
    logic          beat_sop  [NS];
    logic          beat_eop  [NS];
    int            beat_cyc  [NS];
    int nbeats, rden_total, stall_viol, credit_viol, max_occ, rel_seen, busy_low;

    always #5 clk = ~clk;

    adc_ram_to_fft_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS),
                            .RAM_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TWOS_COMP(0)) dut (
        .CLOCK(clk), .RESET(rst), .capture_done(capture_done), .fft_finished(fft_finished),
        .ram_address(ram_address), .ram_rden(ram_rden), .ram_q(ram_q),
        .fft_data(fft_data), .fft_valid(fft_valid), .fft_ready(fft_ready),
        .fft_sop(fft_sop), .fft_eop(fft_eop), .capture_release(capture_release), .busy(busy));

    adc_ram_to_fft_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS),
                            .RAM_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TWOS_COMP(1)) dut_tc (
        .CLOCK(clk), .RESET(rst), .capture_done(cd_tc), .fft_finished(ff_tc),
        .ram_address(addr_tc), .ram_rden(rden_tc), .ram_q(q_tc),
        .fft_data(fd_tc), .fft_valid(fv_tc), .fft_ready(fr_tc),
        .fft_sop(sop_tc), .fft_eop(eop_tc), .capture_release(rel_tc), .busy(busy_tc));

    // Two-stage read pipeline: data for the address strobed in cycle n is on ram_q in cycle n+2.
    always @(posedge clk) begin
        q_p1    <= ram_mem[ram_address];
        ram_q   <= q_p1;
        q_p1_tc <= ram_tc[addr_tc];
        q_tc    <= q_p1_tc;
    end

    // Starts a frame and records every accepted beat plus protocol observations.
    task automatic collect_frame(input bit rand_ready, input bit pulse_in_drain,
                                 output int first_cycle, output bit timed_out);
        int c, issued, popped, occ;
        bit stalled, pulsed;
        logic [DW-1:0] sd;
        logic ss, se;
        for (int k = 0; k < NS; k++) begin
            beat_data[k] = 'x; beat_sop[k] = 1'bx; beat_eop[k] = 1'bx; beat_cyc[k] = -1;
        end
        nbeats = 0; rden_total = 0; stall_viol = 0; credit_viol = 0; max_occ = 0;
        rel_seen = 0; busy_low = 0; first_cycle = -1;
        c = 0; issued = 0; popped = 0; stalled = 1'b0; pulsed = 1'b0;
        sd = '0; ss = 1'b0; se = 1'b0;
        @(posedge clk); #1 capture_done = 1'b1;
        @(posedge clk); #1 capture_done = 1'b0;
        fft_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (nbeats < NS && c < 400) begin
            @(negedge clk);
            c++;
            occ = issued - popped;
            if (occ > max_occ) max_occ = occ;
            if (occ >= DEPTH && ram_rden) credit_viol++;
            if (capture_release) rel_seen++;
            if (!busy) busy_low++;
            if (stalled && (!fft_valid || fft_data !== sd || fft_sop !== ss || fft_eop !== se))
                stall_viol++;
            stalled = fft_valid && !fft_ready;
            sd = fft_data; ss = fft_sop; se = fft_eop;
            if (fft_valid && first_cycle < 0) first_cycle = c;
            if (ram_rden) begin issued++; rden_total++; end
            if (fft_valid && fft_ready) begin
                beat_data[nbeats] = fft_data; beat_sop[nbeats] = fft_sop;
                beat_eop[nbeats] = fft_eop;   beat_cyc[nbeats] = c;
                nbeats++; popped++;
            end
            @(posedge clk); #1;
            fft_finished = 1'b0;
            if (pulse_in_drain && !pulsed && rden_total == NS) begin
                fft_finished = 1'b1; pulsed = 1'b1;
            end
            if (rand_ready) fft_ready = 1'($urandom_range(0, 1));
        end
        fft_finished = 1'b0;
        fft_ready = 1'b1;
        timed_out = (nbeats < NS);
    endtask

    // Lets DRAIN hand over to WAIT_FFT, then pulses fft_finished for one cycle.
    task automatic release_frame();
        repeat (2) @(posedge clk);
        #1 fft_finished = 1'b1;
        @(posedge clk); #1 fft_finished = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({ram_rden, fft_valid, fft_sop, fft_eop, capture_release, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=000000",
                               {ram_rden, fft_valid, fft_sop, fft_eop, capture_release, busy}); end
        checks++; if (ram_address !== 4'h0) begin
            errors++; $display("FAIL reset_addr got=%0h exp=0", ram_address); end
        checks++; if (fft_data !== 12'h000) begin
            errors++; $display("FAIL reset_data got=%0h exp=0", fft_data); end
        checks++; if ({fv_tc, busy_tc, rel_tc, rden_tc} !== 4'b0) begin
            errors++; $display("FAIL reset_tc_flags got=%b exp=0000", {fv_tc, busy_tc, rel_tc, rden_tc}); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, fft_valid, capture_release} !== 3'b0) begin
            errors++; $display("FAIL post_reset_idle got=%b exp=000", {busy, fft_valid, capture_release}); end
    endtask

    task automatic test_stream();
        int fc; bit to; logic [DW-1:0] exp;
        collect_frame(1'b0, 1'b0, fc, to);
        checks++; if (to) begin errors++; $display("FAIL stream_timeout beats=%0d exp=%0d", nbeats, NS); end
        checks++; if (fc != 4) begin errors++; $display("FAIL stream_first_valid got=%0d exp=4", fc); end
        checks++; if (rden_total != NS) begin
            errors++; $display("FAIL stream_reads got=%0d exp=%0d", rden_total, NS); end
        for (int k = 0; k < NS; k++) begin
            exp = 12'(k * 12'h111);
            checks++; if (beat_data[k] !== exp) begin
                errors++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", k, beat_data[k], exp); end
            checks++; if ({beat_sop[k], beat_eop[k]} !== {k == 0, k == NS - 1}) begin
                errors++; $display("FAIL stream_sop_eop[%0d] got=%b%b exp=%b%b", k,
                                   beat_sop[k], beat_eop[k], k == 0, k == NS - 1); end
            checks++; if (beat_cyc[k] != 4 + k) begin
                errors++; $display("FAIL stream_cycle[%0d] got=%0d exp=%0d", k, beat_cyc[k], 4 + k); end
        end
        release_frame();
    endtask

    task automatic test_backpressure();
        int fc; bit to; logic [DW-1:0] exp;
        collect_frame(1'b1, 1'b0, fc, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout beats=%0d exp=%0d", nbeats, NS); end
        for (int k = 0; k < NS; k++) begin
            exp = 12'(k * 12'h111);
            checks++; if (beat_data[k] !== exp || {beat_sop[k], beat_eop[k]} !== {k == 0, k == NS - 1}) begin
                errors++; $display("FAIL bp_beat[%0d] got=%0h/%b%b exp=%0h/%b%b", k, beat_data[k],
                                   beat_sop[k], beat_eop[k], exp, k == 0, k == NS - 1); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        checks++; if (credit_viol != 0) begin errors++; $display("FAIL bp_credit got=%0d exp=0", credit_viol); end
        checks++; if (max_occ > DEPTH) begin errors++; $display("FAIL bp_occupancy got=%0d max=%0d", max_occ, DEPTH); end
        checks++; if (rden_total != NS) begin errors++; $display("FAIL bp_reads got=%0d exp=%0d", rden_total, NS); end
        release_frame();
    endtask

    task automatic test_drain_ignore();
        int fc, bad; bit to;
        collect_frame(1'b0, 1'b1, fc, to);
        bad = 0;
        for (int k = 0; k < NS; k++) if (beat_data[k] !== 12'(k * 12'h111)) bad++;
        checks++; if (to || bad != 0) begin errors++; $display("FAIL drain_frame beats=%0d bad=%0d exp=16/0", nbeats, bad); end
        checks++; if (rel_seen != 0) begin errors++; $display("FAIL drain_release got=%0d exp=0", rel_seen); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL drain_busy_low got=%0d exp=0", busy_low); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({busy, capture_release} !== 2'b10) begin
            errors++; $display("FAIL wait_fft_state got=%b exp=10", {busy, capture_release}); end
        @(posedge clk); #1 fft_finished = 1'b1;
        @(posedge clk); #1 fft_finished = 1'b0;
        @(negedge clk);
        checks++; if ({busy, capture_release} !== 2'b01) begin
            errors++; $display("FAIL release_pulse got=%b exp=01", {busy, capture_release}); end
        @(negedge clk);
        checks++; if ({busy, capture_release} !== 2'b00) begin
            errors++; $display("FAIL release_width got=%b exp=00", {busy, capture_release}); end
    endtask

    task automatic test_mid_reset();
        int c, nb, vis, fc; bit eop_seen, to;
        fft_ready = 1'b1; nb = 0; c = 0; eop_seen = 1'b0;
        @(posedge clk); #1 capture_done = 1'b1;
        @(posedge clk); #1 capture_done = 1'b0;
        while (nb < 8 && c < 100) begin
            @(negedge clk); c++;
            if (fft_eop) eop_seen = 1'b1;
            if (fft_valid && fft_ready) nb++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (nb != 8 || eop_seen) begin
            errors++; $display("FAIL abort_prefix beats=%0d eop=%0b exp=8/0", nb, eop_seen); end
        checks++; if ({ram_rden, fft_valid, fft_sop, fft_eop, capture_release, busy} !== 6'b0) begin
            errors++; $display("FAIL abort_flags got=%b exp=000000",
                               {ram_rden, fft_valid, fft_sop, fft_eop, capture_release, busy}); end
        checks++; if (ram_address !== 4'h0 || fft_data !== 12'h000) begin
            errors++; $display("FAIL abort_buses addr=%0h data=%0h exp=0/0", ram_address, fft_data); end
        vis = 0;
        repeat (6) begin
            @(negedge clk);
            if (fft_valid || capture_release || busy) vis++;
        end
        checks++; if (vis != 0) begin errors++; $display("FAIL abort_quiet got=%0d exp=0", vis); end
        collect_frame(1'b0, 1'b0, fc, to);
        checks++; if (to || fc != 4) begin errors++; $display("FAIL restart_latency got=%0d exp=4", fc); end
        checks++; if (beat_data[0] !== 12'h000 || beat_sop[0] !== 1'b1) begin
            errors++; $display("FAIL restart_first got=%0h/%b exp=0/1", beat_data[0], beat_sop[0]); end
        checks++; if (beat_data[15] !== 12'hFFF || beat_eop[15] !== 1'b1) begin
            errors++; $display("FAIL restart_last got=%0h/%b exp=fff/1", beat_data[15], beat_eop[15]); end
        release_frame();
    endtask

    task automatic test_twos_comp();
        logic [DW-1:0] got [NS];
        int nb, c;
        nb = 0; c = 0;
        for (int k = 0; k < NS; k++) got[k] = 'x;
        @(posedge clk); #1 cd_tc = 1'b1;
        @(posedge clk); #1 cd_tc = 1'b0;
        while (nb < NS && c < 100) begin
            @(negedge clk); c++;
            if (fv_tc && fr_tc) begin got[nb] = fd_tc; nb++; end
            @(posedge clk); #1;
        end
        checks++; if (nb != NS) begin errors++; $display("FAIL tc_beats got=%0d exp=%0d", nb, NS); end
        checks++; if (got[0] !== 12'h800) begin errors++; $display("FAIL tc_000 got=%0h exp=800", got[0]); end
        checks++; if (got[1] !== 12'h000) begin errors++; $display("FAIL tc_800 got=%0h exp=000", got[1]); end
        checks++; if (got[2] !== 12'h7FF) begin errors++; $display("FAIL tc_fff got=%0h exp=7ff", got[2]); end
        checks++; if (got[3] !== 12'hB33) begin errors++; $display("FAIL tc_333 got=%0h exp=b33", got[3]); end
        checks++; if (got[15] !== 12'h7FF) begin errors++; $display("FAIL tc_last got=%0h exp=7ff", got[15]); end
        repeat (2) @(posedge clk);
        #1 ff_tc = 1'b1;
        @(posedge clk); #1 ff_tc = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c, beats, sops, eops, rels, fin_cd, bad_sop;
        logic [DW-1:0] exp;
        beats = 0; sops = 0; eops = 0; rels = 0; fin_cd = 0; bad_sop = 0; c = 0;
        fft_ready = 1'b1;
        @(posedge clk); #1 capture_done = 1'b1;
        while (c < 150) begin
            @(negedge clk); c++;
            if (capture_release) rels++;
            if (fft_valid && fft_ready) begin
                exp = 12'((beats % NS) * 12'h111);
                checks++; if (fft_data !== exp) begin
                    errors++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", beats, fft_data, exp); end
                if (fft_sop) begin
                    sops++;
                    if (fft_data !== 12'h000) bad_sop++;
                end
                if (fft_eop) begin eops++; fin_cd = 3; end
                beats++;
            end
            @(posedge clk); #1;
            fft_finished = 1'b0;
            if (fin_cd > 0) begin
                fin_cd--;
                if (fin_cd == 0) fft_finished = 1'b1;
            end
            if (sops == 2) capture_done = 1'b0;
        end
        capture_done = 1'b0; fft_finished = 1'b0;
        checks++; if (beats != 2 * NS) begin errors++; $display("FAIL b2b_beats got=%0d exp=%0d", beats, 2 * NS); end
        checks++; if (sops != 2 || bad_sop != 0) begin
            errors++; $display("FAIL b2b_sops got=%0d bad=%0d exp=2/0", sops, bad_sop); end
        checks++; if (eops != 2) begin errors++; $display("FAIL b2b_eops got=%0d exp=2", eops); end
        checks++; if (rels != 2) begin errors++; $display("FAIL b2b_releases got=%0d exp=2", rels); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            ram_mem[i] = 12'(i * 12'h111);
            ram_tc[i]  = 12'(i * 12'h111);
        end
        ram_tc[1] = 12'h800;
        ram_tc[2] = 12'hFFF;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain_ignore();
        test_mid_reset();
        test_twos_comp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_ram_to_fft_reader.md
Name: adc_ram_to_fft_reader

Overview:
Read-side counterpart of the ADC capture path. After a full capture frame is in the sample RAM, the block reads the frame out in address order and streams it to the FFT core over a valid/ready interface with start- and end-of-packet markers. It then waits for the FFT to finish and releases the RAM back to the capture writer. It absorbs the RAM read latency with a small credit-controlled FIFO, so FFT backpressure never loses or duplicates a sample.

Parameters:
ADDR_WIDTH, 15, sample RAM address width
DATA_WIDTH, 12, ADC sample width
NUM_SAMPLES, 16384, samples per frame (at most 2^ADDR_WIDTH)
RAM_LATENCY, 2, cycles from ram_rden/ram_address to valid ram_q
FIFO_DEPTH, RAM_LATENCY+2, output FIFO entries
TWOS_COMP, 1, 1 = invert the MSB (offset-binary to two's complement); 0 = pass the sample through unchanged

Ports:
CLOCK  in  1  single system clock; all logic on posedge
RESET  in  1  synchronous, active-high reset
capture_done  in  1  frame fully written to RAM (level, sampled in IDLE only)
fft_finished  in  1  FFT core has consumed the frame and completed (pulse)
ram_address  out  ADDR_WIDTH  read address
ram_rden  out  1  read strobe, one sample per cycle
ram_q  in  DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after the strobe
fft_data  out  DATA_WIDTH  sample to FFT
fft_valid  out  1  fft_data valid
fft_ready  in  1  FFT accepts the beat when fft_valid && fft_ready
fft_sop  out  1  high on beat 0 of the frame
fft_eop  out  1  high on beat NUM_SAMPLES-1
capture_release  out  1  one-cycle pulse: RAM free for the next capture
busy  out  1  state != IDLE

Behaviour:
- Reset values (sync): every output is 0. State returns to IDLE. Counters and FIFO are cleared. The in-flight read tracking shift register (RAM_LATENCY bits) is cleared, so returning RAM data is discarded. No capture_release pulse on reset.
- States and transitions:
  - IDLE: capture_done=1 moves the state to READ. issue_cnt and sent_cnt are set to 0.
  - READ: one read is issued per cycle (ram_rden=1, ram_address=issue_cnt, issue_cnt++) only while fifo_count + inflight_count < FIFO_DEPTH. The issue that makes issue_cnt reach NUM_SAMPLES moves the state to DRAIN.
  - DRAIN: ram_rden=0. Stays here until sent_cnt == NUM_SAMPLES, then moves to WAIT_FFT.
  - WAIT_FFT: fft_finished=1 returns the state to IDLE and drives capture_release=1 for exactly the next cycle.
- Reads: ram_q is pushed into the FIFO when the in-flight tracking bit emerges after RAM_LATENCY cycles. The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error and carries a sim assertion.
- Output: fft_valid = FIFO non-empty. fft_data, fft_sop and fft_eop come from the FIFO head and are held stable while fft_valid && !fft_ready. A beat pops when fft_valid && fft_ready, and sent_cnt increments. fft_sop = (sent_cnt==0); fft_eop = (sent_cnt==NUM_SAMPLES-1).
- Data conversion: fft_data = TWOS_COMP ? {~ram_q[MSB], ram_q[MSB-1:0]} : ram_q.
- Latency and throughput: with fft_ready held high, the first fft_valid occurs RAM_LATENCY+2 cycles after the edge that samples capture_done. After that, one beat per cycle with no bubbles. A full frame completes in NUM_SAMPLES+RAM_LATENCY+2 cycles.
- Simultaneous events: a push and a pop in the same cycle leave fifo_count unchanged. A pop freeing a slot allows an issue in the following cycle, not the same cycle.
- Ignored inputs:
  - capture_done outside IDLE.
  - fft_finished outside WAIT_FFT.
  - A capture_done held high continuously starts exactly one frame per capture_release; the next frame starts from IDLE on the cycle after the return.
- Width rules: issue_cnt and sent_cnt are ADDR_WIDTH+1 bits so NUM_SAMPLES = 2^ADDR_WIDTH is representable. ram_address = issue_cnt[ADDR_WIDTH-1:0]. Counters never wrap within a frame.
- Reset mid-frame: the frame is aborted without an eop. The next capture_done restarts at address 0 with sop.

Test Plan:
1. NUM_SAMPLES=16, RAM_LATENCY=2, ram[i]=i*0x111 (mod 12 bit), TWOS_COMP=0, fft_ready=1 -> 16 consecutive beats of data i*0x111; first fft_valid 4 cycles after capture_done is sampled; sop on beat 0 only, eop on beat 15 only.
2. Same frame, fft_ready random at 50% -> the exact 16-value sequence arrives with no drop or duplicate; fft_data/sop/eop stable during stalls; fifo_count never exceeds 4; ram_rden low whenever the credit is exhausted.
3. fft_finished pulsed during DRAIN -> ignored, busy stays 1. After eop, an fft_finished pulse gives capture_release=1 for exactly 1 cycle, then busy=0.
4. RESET asserted after beat 7 accepted -> next cycle every output is 0 and no capture_release. A new capture_done restarts at address 0 with sop and data ram[0].
5. TWOS_COMP=1, ram values 0x000, 0x800, 0xFFF -> fft_data 0x800, 0x000, 0x7FF.
6. capture_done held high through two full frames with fft_finished pulsed once each -> exactly two frames and two capture_release pulses, each frame starting at address 0.
